pie_tx_framer: RTL and testbench
================================

# pie_tx_framer

Reader-to-tag transmit framer for the RFID reader datapath. It takes a command word and emits the PIE-encoded (pulse-interval encoding) baseband modulation envelope. The envelope starts with either a full preamble (delimiter, data-0, RTcal, TRcal) or a frame-sync (delimiter, data-0, RTcal), followed by the command bits. It drives the modulator ahead of the transmit chain; the tag response is later picked up by the receive-side preamble detection.

## Interface
- `TARI_CYCLES`, 16: data-0 symbol length in clk cycles.
- `DATA1_CYCLES`, 28: data-1 symbol length in clk cycles.
- `PW_CYCLES`, 8: low-pulse width ending every symbol; must be less than `TARI_CYCLES`.
- `DELIM_CYCLES`, 10: delimiter low time.
- `TRCAL_CYCLES`, 88: TRcal symbol length.
- `MAX_BITS`, 32: command register width.
- `LEN_WIDTH`, 6: width of `cmd_len`.
- Derived localparam: RTCAL_CYCLES = TARI_CYCLES + DATA1_CYCLES (44 by default).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: frame request; accepted only on a rising edge where `ready`=1.
- `preamble_sel` in 1: 1 = full preamble (with TRcal); 0 = frame-sync.
- `cmd_dat` in MAX_BITS: command bits, right-aligned. Sent MSB-first: `cmd_dat[cmd_len-1]` down to `cmd_dat[0]`.
- `cmd_len` in LEN_WIDTH: number of bits to send. Values above MAX_BITS saturate to MAX_BITS.
- `ready` out 1: idle, able to accept `start`.
- `done` out 1: one-cycle pulse at end of frame.
- `tx_out` out 1: modulation envelope. 1 = CW (carrier on), 0 = attenuated.

## Operation
- All outputs are registered.
- Reset values: `tx_out`=1, `ready`=1, `done`=0, state IDLE, counters 0.
- On accept, latch `preamble_sel`, `cmd_dat`, and saturated `cmd_len`. Inputs are ignored afterwards until the next accept.
- State sequence: IDLE → DELIM → DATA0 → RTCAL → [TRCAL only if `preamble_sel`] → BITS → IDLE.
  - BITS is skipped when the latched length is 0.
- DELIM: `tx_out`=0 for DELIM_CYCLES.
- Symbol states (DATA0, RTCAL, TRCAL, each bit in BITS):
  - Symbol length L = TARI_CYCLES, RTCAL_CYCLES, TRCAL_CYCLES, or TARI/DATA1_CYCLES per bit value.
  - A cycle counter runs 0..L-1.
  - `tx_out`=1 while counter < L−PW_CYCLES; `tx_out`=0 for the final PW_CYCLES cycles.
- BITS: a bit index counts from latched length−1 down to 0. The next symbol starts on the cycle immediately after the previous one ends; there are no gaps.
- Leaving the last symbol: return to IDLE, `tx_out`=1, `ready`=1, `done`=1 for exactly one cycle.
- `ready`=0 from the cycle after accept until the `done` cycle. A `start` while busy is ignored with no effect.
- Counter widths must hold max(TRCAL_CYCLES, RTCAL_CYCLES, DELIM_CYCLES) without wrap.

## Timing
- Accept edge E0. `tx_out` first goes low in cycle E0+1 (the first delimiter cycle).
- Frame length F = DELIM + TARI + RTCAL + (TRCAL if full preamble) + Σ bit symbol lengths.
- `tx_out` carries the frame in cycles E0+1 .. E0+F.
- `done`=1, `ready`=1, `tx_out`=1 in cycle E0+F+1.
- A new `start` is accepted at the edge ending the `done` cycle. Its delimiter begins in the following cycle, so back-to-back frames have exactly one CW cycle between them.
- Reset mid-frame: `tx_out` goes to 1 and `ready` to 1 immediately (asynchronously). `done` is not pulsed. Latched data is discarded.

## Test plan
- Frame-sync, `cmd_len`=2, `cmd_dat`=2'b10 → `tx_out` after E0: low 10; high 8 / low 8; high 36 / low 8; high 20 / low 8 (bit 1); high 8 / low 8 (bit 0). F=114, `done` in cycle E0+115.
- Full preamble, `cmd_len`=0 → delimiter, data-0, RTcal, then TRcal as high 80 / low 8. F=158, one `done` pulse, no bit symbols.
- `cmd_len`=40, `cmd_dat`=all ones → exactly 32 data-1 symbols. F=10+16+44+32×28=966.
- `start` held high continuously with `cmd_len`=1 → frames repeat, separated by exactly one `tx_out`=1 cycle (the `done` cycle). `cmd_dat` changes mid-frame do not alter the transmitted frame.
- Assert `rst` during RTcal → `tx_out`=1, `ready`=1 without waiting for a clock edge, and `done` stays 0. After release, a new `start` produces a complete, correct frame.
- Override `PW_CYCLES`=4, `TARI_CYCLES`=12, `DATA1_CYCLES`=20 and send bits 01 → bit symbols are high 8 / low 4, then high 16 / low 4. RTcal is high 28 / low 4.

Source files
------------

// File: rtl/pie_tx_framer.sv
// PIE transmit framer: turns a latched command word into a delimiter/preamble/bit envelope.
// Latency: the delimiter starts one cycle after the accept edge; done pulses one cycle after the last symbol.
// Backpressure: start is accepted only while ready=1; starts seen while busy are dropped.
module pie_tx_framer #(
  parameter int TARI_CYCLES  = 16,
  parameter int DATA1_CYCLES = 28,
  parameter int PW_CYCLES    = 8,
  parameter int DELIM_CYCLES = 10,
  parameter int TRCAL_CYCLES = 88,
  parameter int MAX_BITS     = 32,
  parameter int LEN_WIDTH    = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 preamble_sel,
  input  logic [MAX_BITS-1:0]  cmd_dat,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  output logic                 ready,
  output logic                 done,
  output logic                 tx_out
);

  localparam int RTCAL_CYCLES = TARI_CYCLES + DATA1_CYCLES;
  localparam int MAX_A  = (TRCAL_CYCLES > RTCAL_CYCLES) ? TRCAL_CYCLES : RTCAL_CYCLES;
  localparam int MAX_L  = (MAX_A > DELIM_CYCLES) ? MAX_A : DELIM_CYCLES;
  localparam int CNT_W  = $clog2(MAX_L + 1);
  localparam int IDX_W  = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
  localparam int NLEN_W = $clog2(MAX_BITS + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DELIM = 3'd1;
  localparam logic [2:0] S_DATA0 = 3'd2;
  localparam logic [2:0] S_RTCAL = 3'd3;
  localparam logic [2:0] S_TRCAL = 3'd4;
  localparam logic [2:0] S_BITS  = 3'd5;

  logic [2:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NLEN_W-1:0]   len_q, len_d;
  logic [MAX_BITS-1:0] cmd_q, cmd_d;
  logic                pre_q, pre_d;
  logic                tx_q, tx_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  int                  cur_len;
  int                  nxt_len;
  logic                last_cyc;

  // Length in cycles of the symbol occupying a given state.
  function automatic int sym_len(input logic [2:0] st, input logic bit_val);
    case (st)
      S_DELIM: sym_len = DELIM_CYCLES;
      S_DATA0: sym_len = TARI_CYCLES;
      S_RTCAL: sym_len = RTCAL_CYCLES;
      S_TRCAL: sym_len = TRCAL_CYCLES;
      S_BITS:  sym_len = bit_val ? DATA1_CYCLES : TARI_CYCLES;
      default: sym_len = 1;
    endcase
  endfunction

  // Next-state, counters and registered outputs; tx is derived from the next state so it lines up with it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    len_d    = len_q;
    cmd_d    = cmd_q;
    pre_d    = pre_q;
    done_d   = 1'b0;
    cur_len  = sym_len(state_q, cmd_q[idx_q]);
    last_cyc = (int'(cnt_q) == cur_len - 1);
    if (state_q != S_IDLE) begin
      cnt_d = last_cyc ? '0 : cnt_q + CNT_W'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (start && ready_q) begin
          pre_d   = preamble_sel;
          cmd_d   = cmd_dat;
          len_d   = (int'(cmd_len) > MAX_BITS) ? NLEN_W'(MAX_BITS) : NLEN_W'(cmd_len);
          state_d = S_DELIM;
          cnt_d   = '0;
        end
      end
      S_DELIM: if (last_cyc) state_d = S_DATA0;
      S_DATA0: if (last_cyc) state_d = S_RTCAL;
      S_RTCAL, S_TRCAL: begin
        if (last_cyc) begin
          if (state_q == S_RTCAL && pre_q) begin
            state_d = S_TRCAL;
          end else if (len_q != '0) begin
            state_d = S_BITS;
            idx_d   = IDX_W'(int'(len_q) - 1);
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_BITS: begin
        if (last_cyc) begin
          if (idx_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    nxt_len = sym_len(state_d, cmd_d[idx_d]);
    if (state_d == S_IDLE)       tx_d = 1'b1;
    else if (state_d == S_DELIM) tx_d = 1'b0;
    else                         tx_d = (int'(cnt_d) < nxt_len - PW_CYCLES);
    ready_d = (state_d == S_IDLE);
  end

  // State and output registers; reset forces CW and idle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      cmd_q   <= '0;
      pre_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      cmd_q   <= cmd_d;
      pre_q   <= pre_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign tx_out = tx_q;
  assign ready  = ready_q;
  assign done   = done_q;

endmodule

// File: tb/tb_pie_tx_framer.sv
// Scoreboard bench: stimulus pushes the expected per-cycle {tx_out,done,ready} trace,
// monitors pop and compare on every falling edge; idle cycles must show {1,0,1}.
// A second instance checks overridden symbol timing.
module tb_pie_tx_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, pre_a = 1'b0;
  logic [31:0] dat_a = '0;
  logic [5:0]  len_a = '0;
  logic        start_b = 1'b0, pre_b = 1'b0;
  logic [31:0] dat_b = '0;
  logic [5:0]  len_b = '0;
  logic        ready_a, done_a, tx_a;
  logic        ready_b, done_b, tx_b;

  int checks = 0;
  int errors = 0;
  bit in_rst = 1'b1;
  logic [2:0] exp_a[$];
  logic [2:0] exp_b[$];
  bit frame_tx[$];
  logic [2:0] ea, eb;

  always #5 clk = ~clk;

  pie_tx_framer dut_a (
    .clk(clk), .rst(rst), .start(start_a), .preamble_sel(pre_a),
    .cmd_dat(dat_a), .cmd_len(len_a), .ready(ready_a), .done(done_a), .tx_out(tx_a)
  );

  pie_tx_framer #(.PW_CYCLES(4), .TARI_CYCLES(12), .DATA1_CYCLES(20)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .preamble_sel(pre_b),
    .cmd_dat(dat_b), .cmd_len(len_b), .ready(ready_b), .done(done_b), .tx_out(tx_b)
  );

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t {tx,done,ready} got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Reference model: envelope as a list of cycles built from symbol lengths.
  task automatic sym(input int len, input int pw);
    for (int i = 0; i < len - pw; i++) frame_tx.push_back(1'b1);
    for (int i = 0; i < pw; i++) frame_tx.push_back(1'b0);
  endtask

  task automatic gen_frame(input bit pre, input logic [31:0] dat, input int len,
                           input int tari, input int d1, input int pw);
    int n;
    frame_tx.delete();
    for (int i = 0; i < 10; i++) frame_tx.push_back(1'b0);
    sym(tari, pw);
    sym(tari + d1, pw);
    if (pre) sym(88, pw);
    n = (len > 32) ? 32 : len;
    for (int i = n - 1; i >= 0; i--) sym(dat[i] ? d1 : tari, pw);
  endtask

  always @(negedge clk) begin
    if (!in_rst) begin
      ea = (exp_a.size() > 0) ? exp_a.pop_front() : 3'b101;
      check("dut_a_cycle", {tx_a, done_a, ready_a}, ea);
      eb = (exp_b.size() > 0) ? exp_b.pop_front() : 3'b101;
      check("dut_b_cycle", {tx_b, done_b, ready_b}, eb);
    end
  end

  // Called just after a falling edge; returns just after the falling edge of the done cycle.
  task automatic send_a(input bit pre, input logic [31:0] dat, input int len, input bit noisy);
    int f;
    pre_a = pre; dat_a = dat; len_a = 6'(len); start_a = 1'b1;
    @(posedge clk);
    gen_frame(pre, dat, len, 16, 28, 8);
    f = frame_tx.size();
    foreach (frame_tx[i]) exp_a.push_back({frame_tx[i], 2'b00});
    exp_a.push_back(3'b111);
    for (int k = 0; k < f; k++) begin
      @(negedge clk);
      start_a = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noisy) begin
        dat_a = $urandom; len_a = 6'($urandom); pre_a = 1'($urandom);
      end
      @(posedge clk);
    end
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int f;
    repeat (2) @(negedge clk);
    check("reset_state", {tx_a, done_a, ready_a}, 3'b101);
    @(negedge clk);
    rst = 1'b0;
    in_rst = 1'b0;
    idle(2);

    send_a(1'b0, 32'h2, 2, 1'b1);
    idle(3);
    send_a(1'b1, 32'hffff_ffff, 0, 1'b1);
    idle(1);
    send_a(1'b0, 32'hffff_ffff, 40, 1'b0);
    idle(2);
    // start held high across frames: gap is exactly the done cycle
    for (int i = 0; i < 4; i++) begin
      send_a(1'($urandom), $urandom, 1, 1'b0);
      start_a = 1'b1;
    end
    start_a = 1'b0;
    idle(2);
    for (int i = 0; i < 10; i++) begin
      send_a(1'($urandom), $urandom, int'($urandom_range(0, 40)), 1'b1);
      idle(int'($urandom_range(0, 3)));
    end

    // reset during RTcal
    pre_a = 1'b0; dat_a = $urandom; len_a = 6'd5; start_a = 1'b1;
    @(posedge clk);
    gen_frame(1'b0, dat_a, 5, 16, 28, 8);
    foreach (frame_tx[i]) exp_a.push_back({frame_tx[i], 2'b00});
    exp_a.push_back(3'b111);
    @(negedge clk);
    start_a = 1'b0;
    repeat (29) @(posedge clk);
    #2;
    in_rst = 1'b1;
    rst = 1'b1;
    #1;
    check("async_reset", {tx_a, done_a, ready_a}, 3'b101);
    exp_a.delete();
    exp_b.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", {tx_a, done_a, ready_a}, 3'b101);
    end
    rst = 1'b0;
    @(negedge clk);
    in_rst = 1'b0;
    idle(1);
    send_a(1'b1, $urandom, 7, 1'b1);
    idle(2);

    // overridden timing instance, bits 01
    pre_b = 1'b0; dat_b = 32'h1; len_b = 6'd2; start_b = 1'b1;
    @(posedge clk);
    gen_frame(1'b0, 32'h1, 2, 12, 20, 4);
    f = frame_tx.size();
    foreach (frame_tx[i]) exp_b.push_back({frame_tx[i], 2'b00});
    exp_b.push_back(3'b111);
    @(negedge clk);
    start_b = 1'b0;
    dat_b = 32'h2;
    repeat (f + 4) @(negedge clk);

    for (int i = 0; i < 2000 && (exp_a.size() > 0 || exp_b.size() > 0); i++) @(negedge clk);
    if (exp_a.size() > 0 || exp_b.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending a=%0d b=%0d expected 0", exp_a.size(), exp_b.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
